// File: rtl/stack_pkg.sv
// Shared types and constants for the Fibonacci frame stack controller.
package stack_pkg;

    localparam int SLOT_W = 2;

    localparam logic [SLOT_W-1:0] W_N    = 2'd0;
    localparam logic [SLOT_W-1:0] W_FLAG = 2'd1;
    localparam logic [SLOT_W-1:0] W_RES  = 2'd2;

    typedef enum logic [3:0] {
        IDLE,
        WR0,
        WR1,
        WR2,
        RD0,
        RD1,
        RD2,
        RD3,
        DONE
    } state_t;

endpackage

// File: rtl/stack_ram.sv
// Single-port stack RAM: synchronous write, synchronous read with one-cycle latency.
module stack_ram #(
    parameter int WORDSIZE = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = $clog2(DEPTH) + 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       addr,
    input  logic [WORDSIZE-1:0] wdata,
    output logic [WORDSIZE-1:0] rdata
);

    logic [WORDSIZE-1:0] mem [0:DEPTH*4-1];

    // NOTE: the array has no reset so it maps onto block RAM; contents are only meaningful below sp.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/stack_frame_ctrl.sv
// Frame stack controller: saves/restores one (n, flag, res) frame per push/pop request.
module stack_frame_ctrl
    import stack_pkg::*;
#(
    parameter int WORDSIZE = 8,
    parameter int DEPTH    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pushSig,
    input  logic                popSig,
    input  logic [WORDSIZE-1:0] n_in,
    input  logic [WORDSIZE-1:0] flag_in,
    input  logic [WORDSIZE-1:0] res_in,
    output logic [WORDSIZE-1:0] n_out,
    output logic [WORDSIZE-1:0] flag_out,
    output logic [WORDSIZE-1:0] res_out,
    output logic                readySig,
    output logic                empty,
    output logic                full,
    output logic                err
);

    localparam int FW  = $clog2(DEPTH);
    localparam int SPW = FW + 1;
    localparam int AW  = FW + SLOT_W;

    state_t              state;
    logic [SPW-1:0]      sp;
    logic                pop_void;
    logic                we;
    logic [FW-1:0]       frame;
    logic [SLOT_W-1:0]   widx;
    logic [AW-1:0]       addr;
    logic [WORDSIZE-1:0] wdata;
    logic [WORDSIZE-1:0] rdata;

    assign empty = (sp == '0);
    assign full  = (sp == SPW'(DEPTH));

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        frame = sp[FW-1:0];
        widx  = W_N;
        wdata = n_in;
        we    = 1'b0;
        case (state)
            WR0: begin widx = W_N;    wdata = n_in;    we = !full; end
            WR1: begin widx = W_FLAG; wdata = flag_in; we = !full; end
            WR2: begin widx = W_RES;  wdata = res_in;  we = !full; end
            RD0: frame = sp[FW-1:0] - FW'(1);
            RD1: widx = W_FLAG;
            RD2: widx = W_RES;
            default: ;
        endcase
        addr = {frame, widx};
    end

    stack_ram #(
        .WORDSIZE (WORDSIZE),
        .DEPTH    (DEPTH),
        .AW       (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sp       <= '0;
            pop_void <= 1'b0;
            n_out    <= '0;
            flag_out <= '0;
            res_out  <= '0;
            readySig <= 1'b0;
            err      <= 1'b0;
        end else begin
            readySig <= 1'b0;
            case (state)
                IDLE: begin
                    if (pushSig) begin
                        state <= WR0;
                    end else if (popSig) begin
                        pop_void <= empty;
                        state    <= RD0;
                    end
                end
                WR0: begin
                    if (full) err <= 1'b1;
                    state <= WR1;
                end
                WR1: state <= WR2;
                WR2: begin
                    if (!full) sp <= sp + SPW'(1);
                    readySig <= 1'b1;
                    state    <= DONE;
                end
                RD0: begin
                    if (pop_void) err <= 1'b1;
                    else          sp  <= sp - SPW'(1);
                    state <= RD1;
                end
                // Read data lags the issued address by one cycle; an empty pop yields zeros.
                RD1: begin
                    n_out <= pop_void ? '0 : rdata;
                    state <= RD2;
                end
                RD2: begin
                    flag_out <= pop_void ? '0 : rdata;
                    state    <= RD3;
                end
                RD3: begin
                    res_out  <= pop_void ? '0 : rdata;
                    readySig <= 1'b1;
                    state    <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_frame_ctrl.sv
// Scoreboard bench for stack_frame_ctrl: a reference stack predicts each popped frame.
module tb_stack_frame_ctrl;
    import stack_pkg::*;

    typedef struct packed {
        logic [7:0] n;
        logic [7:0] f;
        logic [7:0] r;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pushSig = 1'b0;
    logic       popSig = 1'b0;
    logic [7:0] n_in = '0, flag_in = '0, res_in = '0;
    logic [7:0] n_out, flag_out, res_out;
    logic       readySig, empty, full, err;

    int checks = 0;
    int errors = 0;

    frame_t mdl[$];
    frame_t exp_q[$];
    logic   mdl_err = 1'b0;

    stack_frame_ctrl #(.WORDSIZE(8), .DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .pushSig  (pushSig),
        .popSig   (popSig),
        .n_in     (n_in),
        .flag_in  (flag_in),
        .res_in   (res_in),
        .n_out    (n_out),
        .flag_out (flag_out),
        .res_out  (res_out),
        .readySig (readySig),
        .empty    (empty),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".sp"},    32'(dut.sp), 32'(mdl.size()));
        check({tag, ".empty"}, 32'(empty),  32'(mdl.size() == 0));
        check({tag, ".full"},  32'(full),   32'(mdl.size() == 16));
        check({tag, ".err"},   32'(err),    32'(mdl_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        pushSig = 1'b0;
        popSig = 1'b0;
        mdl.delete();
        exp_q.delete();
        mdl_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.state", 32'(dut.state), 32'(IDLE));
        check("rst.ready", 32'(readySig), 32'd0);
        check("rst.outs",  {8'd0, n_out, flag_out, res_out}, 32'd0);
        check_status("rst");
        rst = 1'b1;
    endtask

    // Drives one request from IDLE, waits for readySig, then scores the result.
    task automatic do_op(input string tag, input bit is_push, input bit is_pop,
                         input frame_t fr, input int exp_lat);
        int  lat;
        bit  seen;
        bit  pop_only;
        frame_t got;
        frame_t e;
        @(negedge clk);
        n_in = fr.n; flag_in = fr.f; res_in = fr.r;
        pushSig = is_push;
        popSig = is_pop;
        pop_only = !is_push && is_pop;
        if (is_push) begin
            if (mdl.size() == 16) mdl_err = 1'b1;
            else mdl.push_back(fr);
        end else if (is_pop) begin
            if (mdl.size() == 0) begin
                mdl_err = 1'b1;
                exp_q.push_back('0);
            end else begin
                exp_q.push_back(mdl.pop_back());
            end
        end
        lat = 0;
        seen = 0;
        while (!seen && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (readySig) seen = 1;
        end
        pushSig = 1'b0;
        popSig = 1'b0;
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        if (seen && pop_only && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = '{n: n_out, f: flag_out, r: res_out};
            check({tag, ".frame"}, 32'(got), 32'(e));
        end
        check_status(tag);
    endtask

    initial begin
        frame_t fr;
        int     lat;
        int     pulses;
        bit     seen;

        // Basic push/pop round trip
        do_reset();
        do_op("push1", 1, 0, '{n: 8'd5, f: 8'd1, r: 8'd3}, 4);
        do_op("pop1",  0, 1, '0, 5);

        // Fill to full, overflow, then drain in LIFO order
        for (int i = 0; i < 16; i++) begin
            fr = '{n: 8'(i), f: 8'(i + 1), r: 8'(i + 2)};
            do_op($sformatf("fill%0d", i), 1, 0, fr, 4);
        end
        do_op("overflow", 1, 0, '{n: 8'hAA, f: 8'hBB, r: 8'hCC}, 4);
        for (int i = 0; i < 16; i++) begin
            do_op($sformatf("drain%0d", i), 0, 1, '0, 5);
        end
        check("drain.last_n", 32'(n_out), 32'd0);
        check("drain.last_res", 32'(res_out), 32'd2);

        // Underflow on an empty stack
        do_reset();
        do_op("pre_under", 1, 0, '{n: 8'h77, f: 8'h66, r: 8'h55}, 4);
        do_op("pre_under_pop", 0, 1, '0, 5);
        do_op("underflow", 0, 1, '0, 5);

        // Simultaneous request with two frames stored: push wins
        do_reset();
        do_op("pre_both0", 1, 0, '{n: 8'h11, f: 8'h12, r: 8'h13}, 4);
        do_op("pre_both1", 1, 0, '{n: 8'h21, f: 8'h22, r: 8'h23}, 4);
        do_op("both", 1, 1, '{n: 8'h31, f: 8'h32, r: 8'h33}, 4);

        // pushSig held through three completions
        @(negedge clk);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            fr = '{n: 8'(8'h40 + k), f: 8'(8'h50 + k), r: 8'(8'h60 + k)};
            n_in = fr.n; flag_in = fr.f; res_in = fr.r;
            pushSig = 1'b1;
            mdl.push_back(fr);
            lat = 0;
            seen = 0;
            while (!seen && lat < 30) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
                if (readySig) seen = 1;
            end
            if (seen) pulses++;
            check($sformatf("held%0d.gap", k), 32'(lat), (k == 0) ? 32'd4 : 32'd5);
        end
        pushSig = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (readySig) pulses++;
        end
        check("held.pulses", 32'(pulses), 32'd3);
        check_status("held");
        for (int i = 0; i < 6; i++) begin
            do_op($sformatf("held_pop%0d", i), 0, 1, '0, 5);
        end

        // Reset asserted mid-push aborts the frame
        do_reset();
        @(negedge clk);
        n_in = 8'h99; flag_in = 8'h98; res_in = 8'h97;
        pushSig = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("abort.in_wr1", 32'(dut.state), 32'(WR1));
        rst = 1'b0;
        pushSig = 1'b0;
        #1;
        check("abort.state", 32'(dut.state), 32'(IDLE));
        check_status("abort");
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (readySig) pulses++;
        end
        check("abort.no_ready", 32'(pulses), 32'd0);
        check_status("abort_after");

        check("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_frame_ctrl.md
# stack_frame_ctrl

Frame stack controller for the recursive Fibonacci datapath. It serves the `pushSig`/`popSig` requests from the sequencing FSM and saves or restores one call frame of three words (`n`, `flag`, `res`) per request to a single-port stack RAM. It returns a one-cycle `readySig` on completion. It owns the stack pointer and reports empty, full and error status.

## Interface
Parameters:
- `WORDSIZE`, 8, width of each frame word; matches the datapath `wordsize`.
- `DEPTH`, 16, number of frames; must be a power of two, at least 2.

Ports:
- `clk`, in, 1: clock. All state changes on the rising edge.
- `rst`, in, 1: reset. One clock domain; reset is asynchronous and active-low.
- `pushSig`, in, 1: push request. Held high by the requester until `readySig`.
- `popSig`, in, 1: pop request. Same holding rule as `pushSig`.
- `n_in`, `flag_in`, `res_in`, in, `WORDSIZE` each: frame to push. Stable while `pushSig` is high.
- `n_out`, `flag_out`, `res_out`, out, `WORDSIZE` each: last popped frame. Registered and held until the next pop completes.
- `readySig`, out, 1: one-cycle completion pulse.
- `empty`, out, 1: high when `sp == 0`.
- `full`, out, 1: high when `sp == DEPTH`.
- `err`, out, 1: sticky flag for overflow or underflow. Cleared only by reset.

## Operation
- Stack pointer `sp` is `$clog2(DEPTH)+1` bits and counts stored frames. RAM address is `{frame, widx}`, with a 2-bit word index: `N`=0, `FLAG`=1, `RES`=2. Word 3 is unused.
- FSM states: IDLE, WR0, WR1, WR2, RD0, RD1, RD2, RD3, DONE.
- IDLE:
  - If `pushSig` is high, go to WR0.
  - Else if `popSig` is high, go to RD0.
  - If both are high, push wins.
- Push, not full:
  - WR0 writes `n_in` to `{sp, N}`.
  - WR1 writes `flag_in` to `{sp, FLAG}`.
  - WR2 writes `res_in` to `{sp, RES}`; `sp <= sp+1` at the end of WR2.
  - Then DONE.
- Push when full: no RAM write and `sp` unchanged. Still walks WR0–WR2 and pulses `readySig`. `err <= 1`.
- Pop, not empty:
  - RD0 sets `sp <= sp-1` and issues a read of `{sp-1, N}`.
  - RD1 issues FLAG and captures `n_out`.
  - RD2 issues RES and captures `flag_out`.
  - RD3 captures `res_out`.
  - Then DONE.
- Pop when empty: no read and `sp` unchanged. Outputs are loaded with 0. Still walks RD0–RD3 and pulses `readySig`. `err <= 1`.
- DONE: `readySig = 1`; next state is IDLE unconditionally. Requests are never sampled in DONE, so a request still held during the ready cycle cannot be accepted twice.
- Reset values: state IDLE, `sp` 0, `n_out`/`flag_out`/`res_out` 0, `readySig` 0, `err` 0, `empty` 1, `full` 0. RAM contents are not cleared.
- Reset during an operation aborts it. A partially written frame is lost, because `sp` only advances in WR2.

## Timing
- Request high in IDLE at cycle 0: push gives `readySig` in cycle 4; pop gives `readySig` in cycle 5.
- `empty` and `full` are decoded from the registered `sp`. They update in the cycle after WR2 (push) or after RD0 (pop).
- RAM: synchronous write; synchronous read with 1-cycle latency. Data addressed in cycle k is valid in cycle k+1.
- `readySig` is Moore, from the DONE state only. Pushes or pops back-to-back cost 1 IDLE cycle each.
- Write enable is active only in WR0–WR2 and only when not full.

## Structure
- `stack_pkg` holds:
  - the state enum;
  - the word-index constants `W_N`, `W_FLAG`, `W_RES`;
  - the frame slot width of 2 bits.
- Sub-module `stack_ram`: single-port RAM, `DEPTH*4` words × `WORDSIZE`, with ports `clk`, `we`, `addr`, `wdata`, `rdata`.
- FSM, pointer and output registers live in `stack_frame_ctrl`.

## Test plan
- Reset then one push of (n=5, flag=1, res=3) → `readySig` in cycle 4, `sp`=1, `empty`=0; pop → outputs (5,1,3), `readySig` in cycle 5, `empty`=1.
- Push frames (i, i+1, i+2) for i=0..15 → `full`=1 after the 16th push. A 17th push → `readySig` pulses, `err`=1, `sp`=16. 16 pops then return frames in LIFO order, ending with (0,1,2).
- Pop on empty → outputs 0, `readySig` pulses, `err`=1, `sp`=0.
- Hold `pushSig` continuously for 3 requests → exactly 3 frames stored, one per `readySig`, with an IDLE gap between pulses.
- Raise `pushSig` and `popSig` together with `sp`=2 → push executes, `sp`=3.
- Drive `rst`=0 during WR1 → state IDLE, `sp` unchanged at its pre-push value (0 after reset), `readySig` never pulses, `err`=0.
